// File: rtl/apb_master_ctrl.sv
// APB master controller: round-robin arbitration of NUM_REQ local requesters onto one APB bus,
// with IDLE/SETUP/ACCESS sequencing, wait-state handling and an optional ACCESS timeout.
module apb_master_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_grant,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             pselect,
    output logic                             penable,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    input  logic                             pready,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pslverr
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [CNT_W-1:0] wait_cnt;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic             any_req;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] ptr_after;
    int               cand;

    // Winner is the first pending request at or above rr_ptr, wrapping to 0.
    always_comb begin
        any_req = 1'b0;
        win_idx = rr_ptr;
        cand    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (!any_req && req_valid[PTR_W'(cand)]) begin
                any_req = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

    assign ptr_after = (owner == PTR_MAX) ? '0 : owner + 1'b1;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            req_grant <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            pselect   <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            req_grant <= '0;
            rsp_valid <= '0;
            case (state)
                StIdle: begin
                    if (any_req) begin
                        paddr     <= addr_arr[win_idx];
                        pwrite    <= req_write[win_idx];
                        pwdata    <= wdata_arr[win_idx];
                        req_grant <= ONE_HOT0 << win_idx;
                        owner     <= win_idx;
                        pselect   <= 1'b1;
                        penable   <= 1'b0;
                        state     <= StSetup;
                    end
                end
                StSetup: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= StAccess;
                end
                StAccess: begin
                    // Completion takes priority over a timeout firing on the same edge.
                    if (pready) begin
                        rsp_valid <= ONE_HOT0 << owner;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        pselect   <= 1'b0;
                        penable   <= 1'b0;
                        rr_ptr    <= ptr_after;
                        state     <= StIdle;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        rsp_valid <= ONE_HOT0 << owner;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        pselect   <= 1'b0;
                        penable   <= 1'b0;
                        rr_ptr    <= ptr_after;
                        state     <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    pselect <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: hand-computed expectations checked with immediate assertions.
module tb_apb_master_ctrl;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_grant;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        pselect;
    logic        penable;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [7:0]  pwdata;
    logic        pready;
    logic [7:0]  prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .NUM_REQ   (2),
        .TIMEOUT   (15)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pselect   (pselect),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".grant"},   32'(req_grant), 0);
        chk({tag, ".rspv"},    32'(rsp_valid), 0);
        chk({tag, ".rdata"},   32'(rsp_rdata), 0);
        chk({tag, ".err"},     32'(rsp_err),   0);
        chk({tag, ".psel"},    32'(pselect),   0);
        chk({tag, ".pen"},     32'(penable),   0);
        chk({tag, ".paddr"},   32'(paddr),     0);
        chk({tag, ".pwrite"},  32'(pwrite),    0);
        chk({tag, ".pwdata"},  32'(pwdata),    0);
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_write[idx]        = wr;
        req_addr[idx*8 +: 8]  = a;
        req_wdata[idx*8 +: 8] = d;
        req_valid[idx]        = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        preset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b1;
        prdata    = '0;
        pslverr   = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        preset = 1'b0;

        // 1: single write, zero wait states
        set_req(0, 1'b1, 8'h10, 8'hA5);
        step();
        chk("t1.grant", 32'(req_grant), 2'b01);
        chk("t1.psel",  32'(pselect), 1);
        chk("t1.pen",   32'(penable), 0);
        chk("t1.paddr", 32'(paddr), 8'h10);
        chk("t1.pwdata", 32'(pwdata), 8'hA5);
        chk("t1.pwrite", 32'(pwrite), 1);
        req_valid = '0;
        step();
        chk("t1.grant_pulse", 32'(req_grant), 0);
        chk("t1.pen_acc", 32'(penable), 1);
        chk("t1.psel_acc", 32'(pselect), 1);
        step();
        chk("t1.rspv",  32'(rsp_valid), 2'b01);
        chk("t1.err",   32'(rsp_err), 0);
        chk("t1.psel_idle", 32'(pselect), 0);
        chk("t1.pen_idle",  32'(penable), 0);
        chk("t1.paddr_hold", 32'(paddr), 8'h10);
        step();
        chk("t1.rspv_pulse", 32'(rsp_valid), 0);

        // 2: read from requester 1 with 3 wait states
        pready = 1'b0;
        set_req(1, 1'b0, 8'h3C, 8'h00);
        step();
        chk("t2.grant", 32'(req_grant), 2'b10);
        chk("t2.pwrite", 32'(pwrite), 0);
        req_valid = '0;
        step();
        chk("t2.pen", 32'(penable), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2.wait_pen",   32'(penable), 1);
            chk("t2.wait_psel",  32'(pselect), 1);
            chk("t2.wait_paddr", 32'(paddr), 8'h3C);
            chk("t2.wait_rspv",  32'(rsp_valid), 0);
        end
        pready = 1'b1;
        prdata = 8'h5C;
        step();
        chk("t2.rspv",  32'(rsp_valid), 2'b10);
        chk("t2.rdata", 32'(rsp_rdata), 8'h5C);
        chk("t2.err",   32'(rsp_err), 0);
        chk("t2.psel",  32'(pselect), 0);

        // 3: both requesters held valid, round-robin order 0,1,0,1
        set_req(0, 1'b1, 8'h01, 8'h11);
        set_req(1, 1'b1, 8'h02, 8'h22);
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            chk("t3.grant", 32'(req_grant), 32'(exp_g));
            chk("t3.paddr", 32'(paddr), (t % 2 == 0) ? 8'h01 : 8'h02);
            if (t == 3) req_valid = '0;
            step();
            chk("t3.grant_gap", 32'(req_grant), 0);
            step();
            chk("t3.rspv", 32'(rsp_valid), 32'(exp_g));
            chk("t3.grant_done", 32'(req_grant), 0);
        end

        // 4a: timeout after 15 ACCESS cycles
        pready = 1'b0;
        prdata = 8'hFF;
        set_req(0, 1'b0, 8'h20, 8'h00);
        step();
        chk("t4.grant", 32'(req_grant), 2'b01);
        req_valid = '0;
        step();
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t4.wait_pen", 32'(penable), 1);
            chk("t4.wait_rspv", 32'(rsp_valid), 0);
        end
        step();
        chk("t4.to_rspv",  32'(rsp_valid), 2'b01);
        chk("t4.to_err",   32'(rsp_err), 1);
        chk("t4.to_rdata", 32'(rsp_rdata), 0);
        chk("t4.to_psel",  32'(pselect), 0);
        chk("t4.to_pen",   32'(penable), 0);

        // 4b: pready arrives in the 15th ACCESS cycle -> normal completion
        set_req(1, 1'b0, 8'h21, 8'h00);
        step();
        chk("t4b.grant", 32'(req_grant), 2'b10);
        req_valid = '0;
        step();
        for (int i = 0; i < 14; i++) step();
        chk("t4b.pen_15th", 32'(penable), 1);
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 8'h77;
        step();
        chk("t4b.rspv",  32'(rsp_valid), 2'b10);
        chk("t4b.err",   32'(rsp_err), 0);
        chk("t4b.rdata", 32'(rsp_rdata), 8'h77);

        // 5: pslverr with pready=1 reports an error; with pready=0 it is ignored
        pslverr = 1'b1;
        set_req(0, 1'b1, 8'h44, 8'h12);
        step();
        chk("t5.grant", 32'(req_grant), 2'b01);
        req_valid = '0;
        step();
        step();
        chk("t5.rspv",  32'(rsp_valid), 2'b01);
        chk("t5.err",   32'(rsp_err), 1);
        chk("t5.rdata", 32'(rsp_rdata), 0);
        pready = 1'b0;
        set_req(1, 1'b1, 8'h45, 8'h34);
        step();
        chk("t5b.grant", 32'(req_grant), 2'b10);
        req_valid = '0;
        step();
        step();
        step();
        chk("t5b.wait_rspv", 32'(rsp_valid), 0);
        pready  = 1'b1;
        pslverr = 1'b0;
        step();
        chk("t5b.rspv", 32'(rsp_valid), 2'b10);
        chk("t5b.err",  32'(rsp_err), 0);

        // 6: asynchronous reset mid-ACCESS, then pointer restarts at requester 0
        pready = 1'b0;
        set_req(1, 1'b1, 8'h5A, 8'h66);
        step();
        chk("t6.grant", 32'(req_grant), 2'b10);
        req_valid = '0;
        step();
        step();
        chk("t6.pen", 32'(penable), 1);
        preset = 1'b1;
        #1;
        chk_all_zero("t6.async");
        step();
        preset = 1'b0;
        pready = 1'b1;
        step();
        chk("t6.no_rspv", 32'(rsp_valid), 0);
        chk("t6.idle_psel", 32'(pselect), 0);
        set_req(0, 1'b0, 8'h70, 8'h00);
        set_req(1, 1'b0, 8'h71, 8'h00);
        step();
        chk("t6.first_grant", 32'(req_grant), 2'b01);
        chk("t6.paddr", 32'(paddr), 8'h70);
        req_valid = '0;
        prdata = 8'h3E;
        step();
        step();
        chk("t6.rspv",  32'(rsp_valid), 2'b01);
        chk("t6.rdata", 32'(rsp_rdata), 8'h3E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
